// File: rtl/ni_recv_dma.sv
// Receive DMA: stores header, size and payload flits at consecutive RAM addresses; 0-cycle write latency.
// Backpressure: flit_ready_out is a decode of the state register and is low outside HEADER/SIZE/PAYLOAD.
module ni_recv_dma #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int SIZE             = 1024,
    parameter int ADDR_WIDTH       = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cfg_start_in,
    input  logic [ADDR_WIDTH-1:0]       cfg_addr_in,
    input  logic                        cfg_ack_in,
    input  logic                        flit_valid_in,
    input  logic [MEMORY_BUS_WIDTH-1:0] flit_data_in,
    output logic                        flit_ready_out,
    output logic                        mem_enable_out,
    output logic                        mem_wb_out,
    output logic [ADDR_WIDTH-1:0]       mem_addr_out,
    output logic [MEMORY_BUS_WIDTH-1:0] mem_data_out,
    output logic                        busy_out,
    output logic                        done_out,
    output logic [15:0]                 count_out
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HEADER  = 3'd1;
    localparam logic [2:0] SIZE_ST = 3'd2;
    localparam logic [2:0] PAYLOAD = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_next;
    logic [15:0]           remaining;
    logic [15:0]           count;
    logic                  accept;

    assign busy_out       = (state == HEADER) || (state == SIZE_ST) || (state == PAYLOAD);
    assign flit_ready_out = busy_out;
    assign done_out       = (state == DONE);
    assign count_out      = count;

    assign accept         = flit_valid_in && flit_ready_out;
    assign mem_enable_out = accept;
    assign mem_wb_out     = accept;
    assign mem_addr_out   = ptr;
    assign mem_data_out   = accept ? flit_data_in : '0;

    // Wrap at the RAM depth, which need not be a power of two.
    assign ptr_next = (ptr == ADDR_WIDTH'(SIZE - 1)) ? '0 : ptr + ADDR_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            count     <= '0;
        end else begin
            if (accept) begin
                ptr   <= ptr_next;
                count <= count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (cfg_start_in) begin
                        ptr   <= cfg_addr_in;
                        count <= '0;
                        state <= HEADER;
                    end
                end
                HEADER: begin
                    if (accept) state <= SIZE_ST;
                end
                SIZE_ST: begin
                    if (accept) begin
                        remaining <= flit_data_in[15:0];
                        state     <= (flit_data_in[15:0] == 16'd0) ? DONE : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) state <= DONE;
                    end
                end
                DONE: begin
                    // ack wins over a coincident start; the CPU re-issues start.
                    if (cfg_ack_in) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ni_recv_dma.sv
// Directed bench for ni_recv_dma with a behavioural RAM on port B and a write-address log.
module tb_ni_recv_dma;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_start_in = 1'b0;
    logic [9:0]  cfg_addr_in = '0;
    logic        cfg_ack_in = 1'b0;
    logic        flit_valid_in = 1'b0;
    logic [31:0] flit_data_in = '0;
    logic        flit_ready_out;
    logic        mem_enable_out;
    logic        mem_wb_out;
    logic [9:0]  mem_addr_out;
    logic [31:0] mem_data_out;
    logic        busy_out;
    logic        done_out;
    logic [15:0] count_out;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:1023];
    logic [9:0]  wr_log [$];
    int          bad = 0;

    always #5 clock = ~clock;

    ni_recv_dma #(.MEMORY_BUS_WIDTH(32), .SIZE(1024), .ADDR_WIDTH(10)) dut (
        .clock(clock), .reset(reset),
        .cfg_start_in(cfg_start_in), .cfg_addr_in(cfg_addr_in), .cfg_ack_in(cfg_ack_in),
        .flit_valid_in(flit_valid_in), .flit_data_in(flit_data_in), .flit_ready_out(flit_ready_out),
        .mem_enable_out(mem_enable_out), .mem_wb_out(mem_wb_out),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .busy_out(busy_out), .done_out(done_out), .count_out(count_out)
    );

    // RAM port B model plus a protocol watcher on every edge.
    always @(posedge clock) begin
        if (mem_enable_out && mem_wb_out) begin
            mem[mem_addr_out] <= mem_data_out;
            wr_log.push_back(mem_addr_out);
        end
        if ((mem_enable_out !== (flit_valid_in && flit_ready_out)) ||
            (mem_wb_out !== mem_enable_out) ||
            (!mem_enable_out && mem_data_out !== 32'd0) ||
            (mem_enable_out && mem_data_out !== flit_data_in))
            bad <= bad + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        int n;
        n = 0;
        flit_valid_in = 1'b1;
        flit_data_in  = d;
        while (!flit_ready_out && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (flit_ready_out !== 1'b1) begin
            fails++;
            $display("FAIL handshake: ready=%0b after %0d cycles, required 1", flit_ready_out, n);
        end
        tick();
        flit_valid_in = 1'b0;
        flit_data_in  = '0;
    endtask

    task automatic start(input logic [9:0] a);
        cfg_start_in = 1'b1;
        cfg_addr_in  = a;
        tick();
        cfg_start_in = 1'b0;
        cfg_addr_in  = '0;
    endtask

    task automatic ack();
        cfg_ack_in = 1'b1;
        tick();
        cfg_ack_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        tests++;
        if ({flit_ready_out, busy_out, done_out, mem_enable_out, mem_wb_out} !== 5'b0 ||
            count_out !== 16'd0 || mem_addr_out !== 10'd0 || mem_data_out !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%0b busy=%0b done=%0b en=%0b wb=%0b cnt=%0d addr=%h data=%h, required all 0",
                     flit_ready_out, busy_out, done_out, mem_enable_out, mem_wb_out, count_out, mem_addr_out, mem_data_out);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] exp [5];
        int base;
        exp = '{32'hAAAA0001, 32'd3, 32'h11, 32'h22, 32'h33};
        base = wr_log.size();
        start(10'h010);
        tests++;
        if (busy_out !== 1'b1 || flit_ready_out !== 1'b1 || mem_addr_out !== 10'h010 || count_out !== 16'd0) begin
            fails++;
            $display("FAIL basic_armed: busy=%0b rdy=%0b addr=%h cnt=%0d, required 1 1 010 0",
                     busy_out, flit_ready_out, mem_addr_out, count_out);
        end
        // valid stays high across the flit sequence
        for (int i = 0; i < 5; i++) send(exp[i]);
        tests++;
        if (done_out !== 1'b1 || flit_ready_out !== 1'b0 || busy_out !== 1'b0 || count_out !== 16'd5) begin
            fails++;
            $display("FAIL basic_done: done=%0b rdy=%0b busy=%0b cnt=%0d, required 1 0 0 5",
                     done_out, flit_ready_out, busy_out, count_out);
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (mem[10'h010 + i] !== exp[i]) begin
                fails++;
                $display("FAIL basic_ram[%0d]: got %h, required %h", i, mem[10'h010 + i], exp[i]);
            end
        end
        flit_valid_in = 1'b1;
        flit_data_in  = 32'hDEAD0000;
        tick(); tick(); tick();
        flit_valid_in = 1'b0;
        flit_data_in  = '0;
        tests++;
        if (wr_log.size() - base !== 5 || count_out !== 16'd5 || done_out !== 1'b1) begin
            fails++;
            $display("FAIL basic_no_accept_in_done: writes=%0d cnt=%0d done=%0b, required 5 5 1",
                     wr_log.size() - base, count_out, done_out);
        end
        ack();
        tests++;
        if (done_out !== 1'b0 || busy_out !== 1'b0 || count_out !== 16'd5) begin
            fails++;
            $display("FAIL basic_ack: done=%0b busy=%0b cnt=%0d, required 0 0 5", done_out, busy_out, count_out);
        end
    endtask

    task automatic test_zero_size();
        int base;
        base = wr_log.size();
        start(10'h100);
        send(32'hBEEF0000);
        send(32'hFFFF0000);
        tests++;
        if (done_out !== 1'b1 || count_out !== 16'd2) begin
            fails++;
            $display("FAIL zero_size_done: done=%0b cnt=%0d, required 1 2", done_out, count_out);
        end
        flit_valid_in = 1'b1;
        flit_data_in  = 32'hDEAD0003;
        tick(); tick(); tick();
        flit_valid_in = 1'b0;
        flit_data_in  = '0;
        tests++;
        if (wr_log.size() - base !== 2 || count_out !== 16'd2 || mem[10'h101] !== 32'hFFFF0000) begin
            fails++;
            $display("FAIL zero_size_writes: writes=%0d cnt=%0d ram101=%h, required 2 2 ffff0000",
                     wr_log.size() - base, count_out, mem[10'h101]);
        end
        ack();
    endtask

    task automatic test_wrap();
        logic [9:0]  ea [4];
        logic [31:0] ed [4];
        int base;
        ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        ed = '{32'hC0DE0000, 32'd2, 32'h5A, 32'hA5};
        base = wr_log.size();
        start(10'h3FE);
        for (int i = 0; i < 4; i++) send(ed[i]);
        tests++;
        if (wr_log.size() - base !== 4 || done_out !== 1'b1 || count_out !== 16'd4) begin
            fails++;
            $display("FAIL wrap_count: writes=%0d done=%0b cnt=%0d, required 4 1 4",
                     wr_log.size() - base, done_out, count_out);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (wr_log.size() <= base + i || wr_log[base + i] !== ea[i] || mem[ea[i]] !== ed[i]) begin
                fails++;
                $display("FAIL wrap_write[%0d]: addr=%h data=%h, required addr %h data %h", i,
                         (wr_log.size() > base + i) ? wr_log[base + i] : 10'h0, mem[ea[i]], ea[i], ed[i]);
            end
        end
        ack();
    endtask

    task automatic test_gaps();
        logic [31:0] exp [5];
        int gaps [5];
        int base, bad0;
        exp  = '{32'hAAAA0001, 32'd3, 32'h11, 32'h22, 32'h33};
        gaps = '{2, 1, 4, 3, 1};
        base = wr_log.size();
        bad0 = bad;
        start(10'h200);
        for (int i = 0; i < 5; i++) begin
            for (int g = 0; g < gaps[i]; g++) tick();
            send(exp[i]);
        end
        tests++;
        if (wr_log.size() - base !== 5 || done_out !== 1'b1 || count_out !== 16'd5 || bad !== bad0) begin
            fails++;
            $display("FAIL gaps_handshake: writes=%0d done=%0b cnt=%0d protocol_errs=%0d, required 5 1 5 0",
                     wr_log.size() - base, done_out, count_out, bad - bad0);
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (mem[10'h200 + i] !== exp[i]) begin
                fails++;
                $display("FAIL gaps_ram[%0d]: got %h, required %h", i, mem[10'h200 + i], exp[i]);
            end
        end
        ack();
    endtask

    task automatic test_mid_reset();
        start(10'h300);
        send(32'h12340005);
        send(32'd5);
        send(32'h1);
        send(32'h2);
        reset = 1'b1;
        tick();
        tests++;
        if (flit_ready_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 ||
            count_out !== 16'd0 || mem_addr_out !== 10'd0) begin
            fails++;
            $display("FAIL mid_reset: rdy=%0b busy=%0b done=%0b cnt=%0d addr=%h, required 0 0 0 0 000",
                     flit_ready_out, busy_out, done_out, count_out, mem_addr_out);
        end
        reset = 1'b0;
        tick();
        start(10'h040);
        send(32'h77770002);
        send(32'd1);
        send(32'h99);
        tests++;
        if (done_out !== 1'b1 || count_out !== 16'd3 || mem[10'h040] !== 32'h77770002 ||
            mem[10'h041] !== 32'd1 || mem[10'h042] !== 32'h99) begin
            fails++;
            $display("FAIL after_reset_packet: done=%0b cnt=%0d ram=%h %h %h, required 1 3 77770002 1 99",
                     done_out, count_out, mem[10'h040], mem[10'h041], mem[10'h042]);
        end
        ack();
    endtask

    task automatic test_ignored_cfg();
        start(10'h080);
        ack();
        tests++;
        if (busy_out !== 1'b1 || flit_ready_out !== 1'b1 || mem_addr_out !== 10'h080 || count_out !== 16'd0) begin
            fails++;
            $display("FAIL ack_in_header: busy=%0b rdy=%0b addr=%h cnt=%0d, required 1 1 080 0",
                     busy_out, flit_ready_out, mem_addr_out, count_out);
        end
        send(32'h55550003);
        send(32'd3);
        send(32'hA1);
        start(10'h3A0);
        tests++;
        if (busy_out !== 1'b1 || mem_addr_out !== 10'h083 || count_out !== 16'd3) begin
            fails++;
            $display("FAIL start_in_payload: busy=%0b addr=%h cnt=%0d, required 1 083 3",
                     busy_out, mem_addr_out, count_out);
        end
        send(32'hA2);
        send(32'hA3);
        tests++;
        if (done_out !== 1'b1 || count_out !== 16'd5 || mem[10'h080] !== 32'h55550003 ||
            mem[10'h084] !== 32'hA3 || mem[10'h083] !== 32'hA2) begin
            fails++;
            $display("FAIL ignored_cfg_packet: done=%0b cnt=%0d ram80=%h ram83=%h ram84=%h, required 1 5 55550003 a2 a3",
                     done_out, count_out, mem[10'h080], mem[10'h083], mem[10'h084]);
        end
        cfg_start_in = 1'b1;
        cfg_ack_in   = 1'b1;
        cfg_addr_in  = 10'h111;
        tick();
        cfg_start_in = 1'b0;
        cfg_ack_in   = 1'b0;
        cfg_addr_in  = '0;
        tests++;
        if (done_out !== 1'b0 || busy_out !== 1'b0 || flit_ready_out !== 1'b0 || count_out !== 16'd5) begin
            fails++;
            $display("FAIL start_ack_together: done=%0b busy=%0b rdy=%0b cnt=%0d, required 0 0 0 5",
                     done_out, busy_out, flit_ready_out, count_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_size();
        test_wrap();
        test_gaps();
        test_mid_reset();
        test_ignored_cfg();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ni_recv_dma.md
Name: ni_recv_dma

Overview:
- Network-interface receive stage that sits directly upstream of the dual-port packet RAM.
- Accepts flits from the router local port over a valid/ready handshake and writes each accepted flit into the RAM's port B.
- Flits are written at consecutive addresses, starting from a base address armed by the CPU side.
- Signals completion, with the flit count, once a whole packet (header, size, payload) has been stored.

Parameters:
- MEMORY_BUS_WIDTH, 32, flit and RAM word width in bits.
- SIZE, 1024, RAM depth in words; must equal the depth of the attached RAM.
- ADDR_WIDTH, 10, RAM address width; must satisfy 2**ADDR_WIDTH >= SIZE.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_start_in  in  1  one-cycle pulse: arm the receiver.
- cfg_addr_in  in  ADDR_WIDTH  base RAM address, sampled on cfg_start_in.
- cfg_ack_in  in  1  one-cycle pulse: CPU has consumed the packet; release DONE.
- flit_valid_in  in  1  router presents a flit.
- flit_data_in  in  MEMORY_BUS_WIDTH  flit payload.
- flit_ready_out  out  1  receiver accepts the flit this cycle.
- mem_enable_out  out  1  drives the RAM port B enable_in.
- mem_wb_out  out  1  drives the RAM port B wb_in.
- mem_addr_out  out  ADDR_WIDTH  drives the RAM port B addr_in.
- mem_data_out  out  MEMORY_BUS_WIDTH  drives the RAM port B data_in.
- busy_out  out  1  high in states HEADER, SIZE and PAYLOAD.
- done_out  out  1  packet fully stored.
- count_out  out  16  flits stored for the current packet (header + size + payload).

Behaviour:
- States: IDLE, HEADER, SIZE, PAYLOAD, DONE.
- Reset, including mid-packet:
  - Next state IDLE.
  - Write pointer, remaining counter and count_out cleared to 0.
  - All outputs 0.
  - A partially received packet is abandoned; its words already written to RAM are left as they are.
- Handshake:
  - A flit is accepted on a rising edge where flit_valid_in and flit_ready_out are both 1.
  - flit_ready_out = 1 only in HEADER, SIZE and PAYLOAD, and is registered (state-derived, never combinational from flit_valid_in).
  - flit_valid_in may be high while ready is low; the flit is simply not taken.
- Memory write:
  - In the cycle a flit is accepted: mem_enable_out = mem_wb_out = 1, mem_addr_out = write pointer, mem_data_out = flit_data_in. These are combinational from the handshake.
  - The RAM captures the word on that same edge, so write latency is 0 cycles.
  - In all other cycles mem_enable_out = mem_wb_out = 0; mem_addr_out holds the pointer and mem_data_out = 0.
- Pointer:
  - Loaded from cfg_addr_in on an accepted cfg_start_in.
  - Increments by 1 per accepted flit.
  - Wraps from SIZE-1 to 0 (modulo SIZE, not modulo 2**ADDR_WIDTH).
- Transitions:
  - IDLE -> HEADER on cfg_start_in; count_out cleared to 0.
  - HEADER -> SIZE on an accepted flit.
  - SIZE -> PAYLOAD on an accepted flit; remaining = flit_data_in[15:0].
  - SIZE -> DONE directly if flit_data_in[15:0] == 0.
  - PAYLOAD: remaining decrements per accepted flit; -> DONE on the flit where remaining == 1.
  - DONE -> IDLE on cfg_ack_in.
- count_out:
  - Increments per accepted flit; wraps at 16 bits.
  - Holds its value through DONE.
  - Cleared only on reset or on the next cfg_start_in.
- done_out = 1 exactly while in DONE.
- Ignored events:
  - cfg_start_in outside IDLE.
  - cfg_ack_in outside DONE.
- Simultaneous cfg_start_in and cfg_ack_in in DONE: ack is honoured, start is ignored; the CPU must re-issue start.
- Back-to-back packets: a new packet is received only after ack and a fresh start. No flit is accepted in DONE or IDLE.

Test Plan:
- Reset then cfg_start_in with base 0x010; send header 0xAAAA0001, size 3, payloads 0x11, 0x22, 0x33 with valid held high -> RAM[0x010..0x014] = AAAA0001, 3, 11, 22, 33; done_out high the cycle after the last flit; count_out = 5; flit_ready_out low in DONE.
- Size flit = 0 -> exactly 2 writes; done_out after the size flit; count_out = 2; a third valid flit is not accepted.
- Base SIZE-2 (0x3FE), size 2 -> writes land at 0x3FE, 0x3FF, 0x000, 0x001; no write reaches any other address.
- Random valid gaps, 1-4 idle cycles between flits -> same RAM contents as the gapless run; mem_enable_out pulses only on accepted cycles.
- Reset asserted mid-payload (after 2 of 5 payload flits) -> next cycle IDLE, flit_ready_out = 0, count_out = 0, done_out = 0; a new start receives a packet correctly.
- cfg_start_in pulsed during PAYLOAD, and cfg_ack_in pulsed during HEADER -> both ignored; pointer, state and count unchanged; the packet completes normally.
